out_port_buffer_bank: RTL and testbench

Per-output-port buffer bank that sits directly upstream of the output selection/arbitration stage. It holds one FIFO per source port, accepts switched words from the fabric tagged with their source port, and exposes per-port empty flags plus a single shared read port that the output controller steers with `rd_sel`/`rd_en`. Read data appears one cycle after `rd_en`. Overflow and underflow are reported as sticky flags.

---
 rtl/out_port_buffer_bank.sv | 90 +++++++++
 tb/tb_out_port_buffer_bank.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/out_port_buffer_bank.sv
// Per-output-port buffer bank: one FIFO per source port, shared read port.
// Sticky overflow/underflow flags; per-port discard mode for truncated packets.
module out_port_buffer_bank #(
  parameter  int DATA_WIDTH     = 32,
  parameter  int PORT_NUB_TOTAL = 16,
  parameter  int DEPTH          = 64,
  localparam int PORT_WIDTH     = $clog2(PORT_NUB_TOTAL),
  localparam int PTR_W          = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_vld,
  input  logic [PORT_WIDTH-1:0]     wr_port,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_eop,
  input  logic [PORT_WIDTH-1:0]     rd_sel,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic [PORT_NUB_TOTAL-1:0] empty,
  output logic [PORT_NUB_TOTAL-1:0] full,
  output logic [PORT_NUB_TOTAL-1:0] almost_full,
  output logic [PORT_NUB_TOTAL-1:0] overflow,
  output logic [PORT_NUB_TOTAL-1:0] underflow
);

  logic [DATA_WIDTH-1:0] mem [PORT_NUB_TOTAL*DEPTH];

  logic [PTR_W-1:0] wr_addr [PORT_NUB_TOTAL];
  logic [PTR_W-1:0] rd_addr [PORT_NUB_TOTAL];
  logic [PORT_NUB_TOTAL-1:0] wr_acc;
  logic [PORT_NUB_TOTAL-1:0] rd_acc;

  for (genvar p = 0; p < PORT_NUB_TOTAL; p++) begin : g_port
    logic [PTR_W:0] wp_q;
    logic [PTR_W:0] rp_q;
    logic [PTR_W:0] cnt;
    logic           disc_q;
    logic           ovf_q;
    logic           udf_q;
    logic           wr_hit;
    logic           rd_hit;

    assign cnt            = wp_q - rp_q;
    assign empty[p]       = (cnt == '0);
    assign full[p]        = (cnt == (PTR_W+1)'(DEPTH));
    assign almost_full[p] = (cnt >= (PTR_W+1)'(DEPTH-2));

    assign wr_hit    = wr_vld && (wr_port == PORT_WIDTH'(p));
    assign rd_hit    = rd_en && (rd_sel == PORT_WIDTH'(p));
    assign wr_acc[p] = wr_hit && !full[p] && !disc_q;
    assign rd_acc[p] = rd_hit && !empty[p];

    assign wr_addr[p]   = wp_q[PTR_W-1:0];
    assign rd_addr[p]   = rp_q[PTR_W-1:0];
    assign overflow[p]  = ovf_q;
    assign underflow[p] = udf_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp_q   <= '0;
        rp_q   <= '0;
        disc_q <= 1'b0;
        ovf_q  <= 1'b0;
        udf_q  <= 1'b0;
      end else begin
        if (wr_acc[p]) wp_q <= wp_q + 1'b1;
        if (rd_acc[p]) rp_q <= rp_q + 1'b1;
        // A dropped word without eop leaves the rest of its packet to be dropped
        if (wr_hit && !wr_acc[p]) begin
          ovf_q  <= 1'b1;
          disc_q <= !wr_eop;
        end
        if (rd_hit && empty[p]) udf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (|wr_acc) mem[{wr_port, wr_addr[wr_port]}] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (|rd_acc) begin
      data_out <= mem[{rd_sel, rd_addr[rd_sel]}];
    end
  end

endmodule

// File: tb/tb_out_port_buffer_bank.sv
// Directed bench for out_port_buffer_bank: vector table plus
// hand-written fill/discard, wrap and mid-stream reset sequences.
module tb_out_port_buffer_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_vld;
  logic [3:0]  wr_port;
  logic [31:0] wr_data;
  logic        wr_eop;
  logic [3:0]  rd_sel;
  logic        rd_en;
  logic [31:0] data_out;
  logic [15:0] empty;
  logic [15:0] full;
  logic [15:0] almost_full;
  logic [15:0] overflow;
  logic [15:0] underflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wv;
    logic [3:0]  wp;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [3:0]  rs;
    logic [31:0] xd;
    logic [15:0] xe;
    logic [15:0] xu;
  } vec_t;

  vec_t vt [14];

  out_port_buffer_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_vld      (wr_vld),
    .wr_port     (wr_port),
    .wr_data     (wr_data),
    .wr_eop      (wr_eop),
    .rd_sel      (rd_sel),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [3:0] wp,
                       input logic [31:0] wd, input logic we,
                       input logic re, input logic [3:0] rs);
    wr_vld  = wv;
    wr_port = wp;
    wr_data = wd;
    wr_eop  = we;
    rd_en   = re;
    rd_sel  = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100us;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 4'd5, 32'hA0, 1'b0, 1'b0, 4'd0, 32'h0,  16'hFFDF, 16'h0};
    vt[1]  = '{1'b1, 4'd5, 32'hA1, 1'b0, 1'b0, 4'd0, 32'h0,  16'hFFDF, 16'h0};
    vt[2]  = '{1'b1, 4'd5, 32'hA2, 1'b1, 1'b0, 4'd0, 32'h0,  16'hFFDF, 16'h0};
    vt[3]  = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 4'd5, 32'hA0, 16'hFFDF, 16'h0};
    vt[4]  = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 4'd5, 32'hA1, 16'hFFDF, 16'h0};
    vt[5]  = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 4'd5, 32'hA2, 16'hFFFF, 16'h0};
    vt[6]  = '{1'b1, 4'd2, 32'hB0, 1'b0, 1'b0, 4'd0, 32'hA2, 16'hFFFB, 16'h0};
    vt[7]  = '{1'b1, 4'd2, 32'hB1, 1'b1, 1'b1, 4'd2, 32'hB0, 16'hFFFB, 16'h0};
    vt[8]  = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 4'd2, 32'hB1, 16'hFFFF, 16'h0};
    vt[9]  = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 4'd7, 32'hB1, 16'hFFFF, 16'h0080};
    vt[10] = '{1'b1, 4'd7, 32'hC0, 1'b1, 1'b0, 4'd0, 32'hB1, 16'hFF7F, 16'h0080};
    vt[11] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 4'd7, 32'hC0, 16'hFFFF, 16'h0080};
    vt[12] = '{1'b1, 4'd7, 32'hC1, 1'b1, 1'b1, 4'd7, 32'hC0, 16'hFF7F, 16'h0080};
    vt[13] = '{1'b0, 4'd0, 32'h0,  1'b0, 1'b1, 4'd7, 32'hC1, 16'hFFFF, 16'h0080};

    rst_n = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);
    tick();
    tick();
    chk("rst data_out", data_out, 32'h0);
    chk("rst empty", {16'h0, empty}, 32'hFFFF);
    chk("rst full", {16'h0, full}, 32'h0);
    chk("rst almost_full", {16'h0, almost_full}, 32'h0);
    chk("rst overflow", {16'h0, overflow}, 32'h0);
    chk("rst underflow", {16'h0, underflow}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].wv, vt[i].wp, vt[i].wd, vt[i].we, vt[i].re, vt[i].rs);
      tick();
      chk($sformatf("vec%0d data", i), data_out, vt[i].xd);
      chk($sformatf("vec%0d empty", i), {16'h0, empty}, {16'h0, vt[i].xe});
      chk($sformatf("vec%0d overflow", i), {16'h0, overflow}, 32'h0);
      chk($sformatf("vec%0d underflow", i), {16'h0, underflow},
          {16'h0, vt[i].xu});
    end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);

    // Fill port 0, then overflow into discard mode
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 4'd0, 32'h100 + i, 1'b0, 1'b0, 4'd0);
      tick();
      chk($sformatf("fill%0d af", i), {31'h0, almost_full[0]},
          (i + 1 >= 62) ? 32'h1 : 32'h0);
      chk($sformatf("fill%0d full", i), {31'h0, full[0]},
          (i == 63) ? 32'h1 : 32'h0);
    end
    chk("fill ovf clean", {31'h0, overflow[0]}, 32'h0);
    drive(1'b1, 4'd0, 32'h140, 1'b0, 1'b0, 4'd0);
    tick();
    chk("ovf set", {31'h0, overflow[0]}, 32'h1);
    chk("ovf still full", {31'h0, full[0]}, 32'h1);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd0);
    tick();
    chk("ovf pop head", data_out, 32'h100);
    chk("ovf pop not full", {31'h0, full[0]}, 32'h0);
    drive(1'b1, 4'd0, 32'h141, 1'b0, 1'b0, 4'd0);
    tick();
    chk("discard mid", {31'h0, full[0]}, 32'h0);
    drive(1'b1, 4'd0, 32'h142, 1'b1, 1'b0, 4'd0);
    tick();
    chk("discard eop", {31'h0, full[0]}, 32'h0);
    drive(1'b1, 4'd0, 32'h1FF, 1'b1, 1'b0, 4'd0);
    tick();
    chk("after discard", {31'h0, full[0]}, 32'h1);
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd0);
      tick();
      chk($sformatf("drain%0d", i), data_out,
          (i < 63) ? 32'h101 + i : 32'h1FF);
    end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);
    chk("drain empty", {31'h0, empty[0]}, 32'h1);

    // Streaming through port 3 with pointer wrap
    for (int k = 0; k <= 70; k++) begin
      drive(k < 70, 4'd3, 32'h300 + k, k == 69, k >= 1, 4'd3);
      tick();
      if (k >= 1) chk($sformatf("stream%0d", k), data_out, 32'h300 + k - 1);
    end
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);
    chk("stream empty", {31'h0, empty[3]}, 32'h1);
    chk("all overflow", {16'h0, overflow}, 32'h0001);
    chk("all underflow", {16'h0, underflow}, 32'h0080);

    // Interleaved writes, then reset mid-stream
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, (k % 2 == 1) ? 4'd15 : 4'd1, 32'h600 + k, 1'b0,
            1'b0, 4'd0);
      tick();
    end
    chk("ilv empty", {16'h0, empty}, 32'h7FFD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst data_out", data_out, 32'h0);
    chk("mrst empty", {16'h0, empty}, 32'hFFFF);
    chk("mrst full", {16'h0, full}, 32'h0);
    chk("mrst almost_full", {16'h0, almost_full}, 32'h0);
    chk("mrst overflow", {16'h0, overflow}, 32'h0);
    chk("mrst underflow", {16'h0, underflow}, 32'h0);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
